uart_rx: RTL and testbench

Oversampling UART receiver that deserialises one asynchronous frame at a time from `RX_IN`. A frame is a start bit, 8 data bits, an optional parity bit and one stop bit. The block presents the byte on `P_DATA` with a one-cycle `DATA_VALID` strobe and reports parity and stop-bit errors. It sits in the receive path of the system's UART, in the UART clock domain, and is clocked at `PRESCALE` times the bit rate.

---
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, 8 data bits MSB-first, optional parity, one stop bit).
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 majority around mid-bit.
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] PRESCALE,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       DATA_VALID,
  output logic [7:0] P_DATA,
  output logic       PAR_ERR,
  output logic       STP_ERR
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, next_state;
  logic [5:0] edge_cnt;
  logic [2:0] bit_idx;
  logic [5:0] half;
  logic       at_decide;
  logic       at_boundary;
  logic       mid_sample;
  logic       sampled_bit;

  assign half        = {1'b0, PRESCALE[5:1]};
  assign at_decide   = (edge_cnt == half + 6'd1);
  assign at_boundary = (edge_cnt == PRESCALE - 6'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mid_sample <= 1'b1;
    end else if (edge_cnt == half) begin
      mid_sample <= RX_IN;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic early_sample;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      early_sample <= 1'b1;
    end else if (edge_cnt == half - 6'd1) begin
      early_sample <= RX_IN;
    end
  end

  // The third vote is the live line value on the decision cycle itself.
  assign sampled_bit = (early_sample & mid_sample) | (early_sample & RX_IN) | (mid_sample & RX_IN);
`else
  assign sampled_bit = mid_sample;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // STOP leaves at the sample point so a start bit right after the stop bit is caught.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START: begin
        if (at_decide && sampled_bit) next_state = IDLE;
        else if (at_boundary)         next_state = DATA;
      end
      DATA:    if (at_boundary && bit_idx == 3'd0) next_state = PAR_EN ? PARITY : STOP;
      PARITY:  if (at_boundary) next_state = STOP;
      STOP:    if (at_decide) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // bit_idx wraps back to 0 after the 8th data sample, which marks the end of the data phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_idx    <= '0;
      P_DATA     <= '0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (state == IDLE || next_state == IDLE || at_boundary) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (state == IDLE) begin
        bit_idx <= '0;
        if (!RX_IN) begin
          PAR_ERR <= 1'b0;
          STP_ERR <= 1'b0;
        end
      end
      if (at_decide) begin
        case (state)
          DATA: begin
            P_DATA  <= {P_DATA[6:0], sampled_bit};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY:  PAR_ERR <= sampled_bit ^ (^P_DATA) ^ PAR_TYP;
          STOP: begin
            STP_ERR    <= ~sampled_bit;
            DATA_VALID <= sampled_bit & ~PAR_ERR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; a frame-level model queues expected outcomes,
// a negedge monitor pops them on each DATA_VALID pulse or error-flag rise.
module tb_uart_rx;

  typedef enum int {GOOD, BAD_PAR, BAD_STOP} outcome_t;
  typedef struct {
    logic [7:0] data;
    outcome_t   kind;
  } exp_t;

  logic       CLK_tb = 1'b0;
  logic       RST_tb;
  logic       RX_IN_tb;
  logic [5:0] PRESCALE_tb;
  logic       PAR_EN_tb;
  logic       PAR_TYP_tb;
  logic       DATA_VALID_tb;
  logic [7:0] P_DATA_tb;
  logic       PAR_ERR_tb;
  logic       STP_ERR_tb;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         valid_count = 0;
  int         exp_valid_count = 0;
  logic [7:0] last_data = 8'h00;
  logic       dv_q = 1'b0;
  logic       perr_q = 1'b0;
  logic       serr_q = 1'b0;
  int         presc_list[3] = '{8, 16, 32};

  always #5 CLK_tb = ~CLK_tb;

  uart_rx dut (
    .CLK        (CLK_tb),
    .RST        (RST_tb),
    .RX_IN      (RX_IN_tb),
    .PRESCALE   (PRESCALE_tb),
    .PAR_EN     (PAR_EN_tb),
    .PAR_TYP    (PAR_TYP_tb),
    .DATA_VALID (DATA_VALID_tb),
    .P_DATA     (P_DATA_tb),
    .PAR_ERR    (PAR_ERR_tb),
    .STP_ERR    (STP_ERR_tb)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_event(input outcome_t kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_event: got outcome %0d, expected no frame pending", kind);
      return;
    end
    e = exp_q.pop_front();
    check_output("outcome", 32'(kind), 32'(e.kind));
    check_output("p_data", 32'(P_DATA_tb), 32'(e.data));
    check_output("par_err", 32'(PAR_ERR_tb), 32'(e.kind == BAD_PAR));
    check_output("stp_err", 32'(STP_ERR_tb), 32'(e.kind == BAD_STOP));
  endtask

  // Each outcome is signalled by exactly one of: a DATA_VALID pulse, a PAR_ERR rise, a STP_ERR rise.
  always @(negedge CLK_tb) begin
    if (RST_tb) begin
      if (DATA_VALID_tb) begin
        valid_count++;
        check_output("dv_single_cycle", 32'(dv_q), 32'd0);
        check_event(GOOD);
      end
      if (PAR_ERR_tb && !perr_q) check_event(BAD_PAR);
      if (STP_ERR_tb && !serr_q) check_event(BAD_STOP);
    end
    dv_q   = DATA_VALID_tb;
    perr_q = PAR_ERR_tb;
    serr_q = STP_ERR_tb;
  end

  task automatic drive_bit(input logic b);
    RX_IN_tb = b;
    repeat (PRESCALE_tb) @(posedge CLK_tb);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic par_en, input logic par_typ,
                                input int presc, input outcome_t kind, input int gap_bits);
    logic par_bit;
    PRESCALE_tb = 6'(presc);
    PAR_EN_tb   = par_en;
    PAR_TYP_tb  = par_typ;
    par_bit = logic'(($countones(d) % 2) == 1) ^ par_typ;
    if (kind == BAD_PAR) par_bit = ~par_bit;
    exp_q.push_back('{d, kind});
    last_data = d;
    if (kind == GOOD) exp_valid_count++;
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(kind != BAD_STOP);
    RX_IN_tb = 1'b1;
    repeat (gap_bits * presc) @(posedge CLK_tb);
    #1;
  endtask

  task automatic wait_drain();
    int budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge CLK_tb);
      budget--;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d frames pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_data_valid"}, 32'(DATA_VALID_tb), 32'd0);
    check_output({tag, "_p_data"}, 32'(P_DATA_tb), 32'd0);
    check_output({tag, "_par_err"}, 32'(PAR_ERR_tb), 32'd0);
    check_output({tag, "_stp_err"}, 32'(STP_ERR_tb), 32'd0);
  endtask

  initial begin
    #3_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    outcome_t   kind;
    logic       pe;
    int         presc;
    int         gap;
    logic [7:0] d;

    RST_tb = 1'b0;
    RX_IN_tb = 1'b1;
    PRESCALE_tb = 6'd8;
    PAR_EN_tb = 1'b0;
    PAR_TYP_tb = 1'b0;
    repeat (3) @(posedge CLK_tb);
    @(negedge CLK_tb);
    check_reset_outputs("reset");
    @(posedge CLK_tb);
    #1;
    RST_tb = 1'b1;
    repeat (2) @(posedge CLK_tb);
    #1;

    $display("[TB] directed frames");
    foreach (presc_list[i]) begin
      apply_stimulus(8'hAA, 1'b1, 1'b0, presc_list[i], GOOD, 1);
      apply_stimulus(8'hAA, 1'b1, 1'b1, presc_list[i], GOOD, 1);
      apply_stimulus(8'hAA, 1'b0, 1'b0, presc_list[i], GOOD, 1);
    end
    apply_stimulus(8'hAA, 1'b1, 1'b0, 8, GOOD, 0);
    apply_stimulus(8'hEA, 1'b1, 1'b0, 8, GOOD, 1);
    apply_stimulus(8'hAA, 1'b1, 1'b0, 8, BAD_PAR, 1);
    apply_stimulus(8'hAA, 1'b1, 1'b0, 8, BAD_STOP, 2);
    wait_drain();

    $display("[TB] start glitch");
    PRESCALE_tb = 6'd16;
    RX_IN_tb = 1'b0;
    repeat (2) @(posedge CLK_tb);
    #1;
    RX_IN_tb = 1'b1;
    repeat (48) @(posedge CLK_tb);
    @(negedge CLK_tb);
    check_output("glitch_p_data", 32'(P_DATA_tb), 32'(last_data));
    check_output("glitch_valid_count", 32'(valid_count), 32'(exp_valid_count));
    check_output("glitch_stp_err", 32'(STP_ERR_tb), 32'd0);
    @(posedge CLK_tb);
    #1;

    $display("[TB] reset mid-frame");
    PRESCALE_tb = 6'd8;
    PAR_EN_tb = 1'b0;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 7; i >= 5; i--) drive_bit(d[i]);
    RST_tb = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    RX_IN_tb = 1'b1;
    @(posedge CLK_tb);
    #1;
    RST_tb = 1'b1;
    repeat (16) @(posedge CLK_tb);
    #1;

    $display("[TB] random frames");
    for (int n = 0; n < 30; n++) begin
      d     = 8'($urandom);
      pe    = 1'($urandom);
      presc = presc_list[$urandom_range(0, 2)];
      case ($urandom_range(0, 9))
        0:       kind = pe ? BAD_PAR : GOOD;
        1:       kind = BAD_STOP;
        default: kind = GOOD;
      endcase
      gap = (kind == BAD_STOP) ? 2 : int'($urandom_range(0, 2));
      apply_stimulus(d, pe, 1'($urandom), presc, kind, gap);
    end
    wait_drain();
    repeat (4) @(posedge CLK_tb);
    #1;
    check_output("total_valid_count", 32'(valid_count), 32'(exp_valid_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
